// File: rtl/vecmat_1x64_64x10.sv
// Signed 1x64 by 64x10 vector-matrix multiplier: the final fully-connected layer engine.
// The vector and matrix are captured once, four 16-row PEs accumulate in parallel, and the partial sums are added.

module vector_sel_64_col (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [1023:0]     ai_i,
  output logic [3:0][255:0] slice_o,
  output logic              done_o
);
  logic [3:0][255:0] slice_q;
  logic              done_q;

  // Slice k is ai elements 16k..16k+15, which is exactly packed word k of ai.
  always_ff @(posedge clk) begin
    if (rst) begin
      slice_q <= '0;
      done_q  <= 1'b0;
    end else if (en_i && !done_q) begin
      slice_q <= ai_i;
      done_q  <= 1'b1;
    end
  end

  assign slice_o = slice_q;
  assign done_o  = done_q;
endmodule

module matrix_sel_64_col (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [10239:0]     matrix_i,
  output logic [3:0][2559:0] slice_o,
  output logic               done_o
);
  logic [3:0][2559:0] slice_q;
  logic               done_q;

  // Row-major layout: rows 16k..16k+15 occupy a contiguous 2560-bit word.
  always_ff @(posedge clk) begin
    if (rst) begin
      slice_q <= '0;
      done_q  <= 1'b0;
    end else if (en_i && !done_q) begin
      slice_q <= matrix_i;
      done_q  <= 1'b1;
    end
  end

  assign slice_o = slice_q;
  assign done_o  = done_q;
endmodule

module top_1x16_16x10 (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [255:0]  a_i,
  input  logic [2559:0] m_i,
  output logic [159:0]  acc_o,
  output logic          done_o
);
  logic [3:0]         row_q;
  logic               done_q;
  logic signed [15:0] acc_q [10];
  logic signed [15:0] acc_d [10];
  logic signed [15:0] a_row;
  logic [159:0]       m_row;

  // Full 32-bit signed product; only its low half survives the mod 2^16 accumulator.
  function automatic logic signed [15:0] mac_wrap(input logic signed [15:0] acc,
                                                  input logic signed [15:0] a,
                                                  input logic signed [15:0] m);
    logic signed [31:0] prod;
    prod = a * m;
    return acc + prod[15:0];
  endfunction

  assign a_row = a_i[{row_q, 4'b0000} +: 16];
  assign m_row = m_i[12'(row_q) * 12'd160 +: 160];

  always_comb begin
    for (int c = 0; c < 10; c++) begin
      acc_d[c] = mac_wrap(acc_q[c], a_row, m_row[16*c +: 16]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      done_q <= 1'b0;
      for (int c = 0; c < 10; c++) acc_q[c] <= '0;
    end else if (en_i && !done_q) begin
      for (int c = 0; c < 10; c++) acc_q[c] <= acc_d[c];
      if (row_q == 4'd15) done_q <= 1'b1;
      else                row_q  <= row_q + 4'd1;
    end
  end

  always_comb begin
    for (int c = 0; c < 10; c++) acc_o[16*c +: 16] = acc_q[c];
  end
  assign done_o = done_q;
endmodule

module vecmat_1x64_64x10 (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1023:0]  ai,
  input  logic [10239:0] matrix,
  output logic [159:0]   psum,
  output logic           finish
);
  logic [3:0][255:0]  vec_slice;
  logic [3:0][2559:0] mat_slice;
  logic [3:0][159:0]  pe_acc;
  logic [3:0]         pe_done;
  logic               vec_done;
  logic               mat_done;
  logic               qual;
  logic [1:0]         cnt_q;
  logic [1:0]         cnt_d;
  logic               finish_q;
  logic               finish_d;

  function automatic logic signed [15:0] sum4_wrap(input logic signed [15:0] s0,
                                                   input logic signed [15:0] s1,
                                                   input logic signed [15:0] s2,
                                                   input logic signed [15:0] s3);
    return s0 + s1 + s2 + s3;
  endfunction

  vector_sel_64_col u_vec (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .ai_i    (ai),
    .slice_o (vec_slice),
    .done_o  (vec_done)
  );

  matrix_sel_64_col u_mat (
    .clk      (clk),
    .rst      (rst),
    .en_i     (vec_done),
    .matrix_i (matrix),
    .slice_o  (mat_slice),
    .done_o   (mat_done)
  );

  for (genvar k = 0; k < 4; k++) begin : g_pe
    top_1x16_16x10 u_pe (
      .clk    (clk),
      .rst    (rst),
      .en_i   (mat_done),
      .a_i    (vec_slice[k]),
      .m_i    (mat_slice[k]),
      .acc_o  (pe_acc[k]),
      .done_o (pe_done[k])
    );
  end

  always_comb begin
    for (int c = 0; c < 10; c++) begin
      psum[16*c +: 16] = sum4_wrap(pe_acc[0][16*c +: 16], pe_acc[1][16*c +: 16],
                                   pe_acc[2][16*c +: 16], pe_acc[3][16*c +: 16]);
    end
  end

  // Two qualifying edges of settling after the PEs finish, finish on the third; en low stalls it.
  assign qual = en & vec_done & mat_done & (&pe_done);

  always_comb begin
    cnt_d    = cnt_q;
    finish_d = finish_q;
    if (qual && !finish_q) begin
      if (cnt_q == 2'd2) finish_d = 1'b1;
      else               cnt_d    = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      finish_q <= finish_d;
    end
  end

  assign finish = finish_q;
endmodule

// File: tb/tb_vecmat_1x64_64x10.sv
// Directed bench for vecmat_1x64_64x10 with a queue of expected results checked when finish rises.

module tb_vecmat_1x64_64x10;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [1023:0]  ai = '0;
  logic [10239:0] matrix = '0;
  logic [159:0]   psum;
  logic           finish;

  int checks = 0;
  int errors = 0;
  logic [159:0] sb[$];

  vecmat_1x64_64x10 dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ai     (ai),
    .matrix (matrix),
    .psum   (psum),
    .finish (finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] model();
    logic [159:0]       r;
    logic signed [31:0] s;
    r = '0;
    for (int c = 0; c < 10; c++) begin
      s = 0;
      for (int row = 0; row < 64; row++)
        s += $signed(ai[16*row +: 16]) * $signed(matrix[16*(10*row+c) +: 16]);
      r[16*c +: 16] = s[15:0];
    end
    return r;
  endfunction

  task automatic fill(input logic [15:0] av, input logic [15:0] mv);
    for (int i = 0; i < 64; i++)  ai[16*i +: 16] = av;
    for (int i = 0; i < 640; i++) matrix[16*i +: 16] = mv;
  endtask

  task automatic scramble();
    for (int i = 0; i < 32; i++)  ai[32*i +: 32] = $urandom;
    for (int i = 0; i < 320; i++) matrix[32*i +: 32] = $urandom;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raises en, counts edges until finish, then pops the expected result.
  task automatic run(input string tag, input int lat, input int stall_at, input int stall_n,
                     input bit perturb);
    int e;
    bit seen;
    logic [159:0] exp;
    sb.push_back(model());
    @(negedge clk);
    en = 1'b1;
    e = 0;
    seen = 1'b0;
    while (!seen && e < 60) begin
      if (stall_n > 0 && e + 1 == stall_at) en = 1'b0;
      if (stall_n > 0 && e + 1 == stall_at + stall_n) en = 1'b1;
      @(posedge clk);
      e++;
      @(negedge clk);
      if (perturb && e == 2) scramble();
      if (stall_n > 0 && e == stall_at) check({tag, "_stall_psum"}, psum, sb[0]);
      if (finish) seen = 1'b1;
    end
    check({tag, "_latency"}, 160'(e), 160'(lat));
    exp = sb.pop_front();
    check({tag, "_psum"}, psum, exp);
    en = 1'b0;
  endtask

  initial begin
    logic [159:0] cexp;

    // Reset with random inputs, en low
    scramble();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_psum", psum, '0);
    check("reset_finish", 160'(finish), 160'(0));
    rst = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("idle_finish", 160'(finish), 160'(0));
    check("idle_psum", psum, '0);

    // All ones: 64 in every column, finish at E21
    fill(16'd1, 16'd1);
    run("ones", 21, 0, 0, 1'b0);
    for (int c = 0; c < 10; c++) cexp[16*c +: 16] = 16'h0040;
    check("ones_const", psum, cexp);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("ones_sticky", 160'(finish), 160'(1));

    // Selection: identity-like matrix picks ai[c]
    do_reset(1);
    fill(16'd0, 16'd0);
    for (int i = 0; i < 64; i++) ai[16*i +: 16] = 16'(i);
    for (int r = 0; r < 10; r++) matrix[16*(10*r+r) +: 16] = 16'd1;
    run("select", 21, 0, 0, 1'b0);
    for (int c = 0; c < 10; c++) cexp[16*c +: 16] = 16'(c);
    check("select_const", psum, cexp);

    // Signed with inputs changed after E2
    do_reset(2);
    fill(16'hFFFF, 16'd2);
    run("signed", 21, 0, 0, 1'b1);
    for (int c = 0; c < 10; c++) cexp[16*c +: 16] = 16'hFF80;
    check("signed_const", psum, cexp);

    // Wrap: 64*300*300 mod 2^16
    do_reset(1);
    fill(16'd300, 16'd300);
    run("wrap", 21, 0, 0, 1'b0);
    for (int c = 0; c < 10; c++) cexp[16*c +: 16] = 16'hE400;
    check("wrap_const", psum, cexp);

    // Random data with en low on E19 and E20
    do_reset(1);
    scramble();
    run("stall", 23, 19, 2, 1'b0);

    // Reset pulse at E10, then a clean random run
    do_reset(1);
    scramble();
    @(negedge clk);
    en = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_psum", psum, '0);
    check("abort_finish", 160'(finish), 160'(0));
    rst = 1'b0;
    en  = 1'b0;
    scramble();
    run("rerun", 21, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
